// File: rtl/food_row_fetcher.sv
// Food map row fetcher: pulls one map row per line into a line buffer and emits a registered pellet mask.
// Optional pellet blinking is compiled in with `define FOOD_BLINK_EN.
module food_row_fetcher #(
  parameter int RATIO        = 16,
  parameter int MAP_COLS     = 80,
  parameter int MAP_ROWS     = 45,
  parameter int READ_LATENCY = 2,
  parameter int DOT_LO       = 6,
  parameter int DOT_HI       = 9,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_start,
  input  logic [9:0]          next_line_y,
  input  logic                frame_start,
  input  logic                video_active,
  input  logic [10:0]         pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic [MAP_COLS-1:0] food_row,
  output logic [5:0]          food_map_read_y,
  output logic                food_pixel,
  output logic                fetch_busy
);

  // RATIO is a power of two, so tile division and modulo reduce to shifts and slices.
  localparam int RS  = $clog2(RATIO);
  localparam int CW  = $clog2(READ_LATENCY + 1);
  localparam int CIW = $clog2(MAP_COLS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [1:0]          state;
  logic [CW-1:0]       wait_cnt;
  logic [MAP_COLS-1:0] line_buf;
  logic [9:0]          row;
  logic                row_on_map;

  assign row        = next_line_y >> RS;
  assign row_on_map = row < 10'(MAP_ROWS);

  // Fetch control: a new line_start always wins, aborting any fetch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      food_map_read_y <= '0;
      fetch_busy      <= 1'b0;
      line_buf        <= '0;
    end else if (line_start) begin
      if (row_on_map) begin
        food_map_read_y <= row[5:0];
        wait_cnt        <= CW'(READ_LATENCY);
        state           <= S_WAIT;
        fetch_busy      <= 1'b1;
      end else begin
        line_buf   <= '0;
        state      <= S_IDLE;
        fetch_busy <= 1'b0;
      end
    end else begin
      case (state)
        S_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == CW'(1)) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          line_buf   <= food_row;
          fetch_busy <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [10:0]    col_full;
  logic           col_ok;
  logic [CIW-1:0] col;
  logic [RS-1:0]  ox;
  logic [RS-1:0]  oy;
  logic           ox_in;
  logic           oy_in;
  logic           blink_on;

  assign col_full = pixel_x >> RS;
  assign col_ok   = col_full < 11'(MAP_COLS);
  assign col      = col_ok ? col_full[CIW-1:0] : '0;
  assign ox       = pixel_x[RS-1:0];
  assign oy       = pixel_y[RS-1:0];
  assign ox_in    = (ox >= RS'(DOT_LO)) && (ox <= RS'(DOT_HI));
  assign oy_in    = (oy >= RS'(DOT_LO)) && (oy <= RS'(DOT_HI));

`ifdef FOOD_BLINK_EN
  logic [7:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
    end else if (frame_start) begin
      blink_cnt <= (blink_cnt == 8'(2 * BLINK_FRAMES - 1)) ? 8'd0 : blink_cnt + 8'd1;
    end
  end

  assign blink_on = blink_cnt < 8'(BLINK_FRAMES);

  logic unused_bits;
  assign unused_bits = ^{next_line_y[RS-1:0], pixel_y[9:RS]};
`else
  assign blink_on = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{next_line_y[RS-1:0], pixel_y[9:RS], frame_start, BLINK_FRAMES[0]};
`endif

  // Pixel stage: one register between pixel coordinates and the mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      food_pixel <= 1'b0;
    end else begin
      food_pixel <= video_active & col_ok & line_buf[col] & ox_in & oy_in & blink_on;
    end
  end

endmodule
